ahb_interconnect_n: RTL and testbench

- Parametrised successor to the fixed 1-upstream/3-downstream AHB-Lite interconnect.
- Connects one upstream manager port (CPU side, s0) to NUM_SUB subordinate ports (packed vectors).
- Decodes address windows and qualifies htrans per subordinate.
- Muxes data-phase responses back to the manager.
- Contains a built-in default subordinate that returns the two-cycle AHB ERROR response for unmapped accesses, and captures error address/count status.

---
 rtl/ahb_interconnect_n.sv | 183 ++++++++++++++++++
 tb/tb_ahb_interconnect_n.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/ahb_interconnect_n.sv
// AHB-Lite 1:N interconnect: address decode, per-subordinate htrans qualification,
// data-phase response mux and a built-in error subordinate with logging.

module ahb_ic_slice (
  input  logic        resetn,
  input  logic        hit,
  input  logic        sel,
  input  logic        up_hready,
  input  logic [1:0]  up_htrans,
  input  logic        sub_hready,
  input  logic        sub_hresp,
  input  logic [31:0] sub_hrdata,
  output logic [1:0]  sub_htrans,
  output logic        rdy_g,
  output logic        rsp_g,
  output logic [31:0] rd_g
);
  // A stalled data phase elsewhere must never let this subordinate see a transfer.
  assign sub_htrans = (resetn && hit && up_hready) ? up_htrans : 2'b00;
  assign rdy_g      = sel & sub_hready;
  assign rsp_g      = sel & sub_hresp;
  assign rd_g       = sel ? sub_hrdata : 32'h0;
endmodule

module ahb_interconnect_n #(
  parameter int          NUM_SUB     = 3,
  parameter int          SEL_LSB     = 12,
  parameter int          SEL_W       = 3,
  parameter logic [31:0] REGION_BASE = 32'h0,
  parameter int          ERR_CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [31:0]                   ahb_s0_haddr_i,
  input  logic                          ahb_s0_hwrite_i,
  input  logic [2:0]                    ahb_s0_hsize_i,
  input  logic [2:0]                    ahb_s0_hburst_i,
  input  logic [3:0]                    ahb_s0_hprot_i,
  input  logic [1:0]                    ahb_s0_htrans_i,
  input  logic                          ahb_s0_hmastlock_i,
  input  logic [31:0]                   ahb_s0_hwdata_i,
  output logic                          ahb_s0_hready_o,
  output logic                          ahb_s0_hresp_o,
  output logic [31:0]                   ahb_s0_hrdata_o,
  output logic [NUM_SUB-1:0][31:0]      ahb_m_haddr_o,
  output logic [NUM_SUB-1:0]            ahb_m_hwrite_o,
  output logic [NUM_SUB-1:0][2:0]       ahb_m_hsize_o,
  output logic [NUM_SUB-1:0][2:0]       ahb_m_hburst_o,
  output logic [NUM_SUB-1:0][3:0]       ahb_m_hprot_o,
  output logic [NUM_SUB-1:0]            ahb_m_hmastlock_o,
  output logic [NUM_SUB-1:0][31:0]      ahb_m_hwdata_o,
  output logic [NUM_SUB-1:0][1:0]       ahb_m_htrans_o,
  input  logic [NUM_SUB-1:0]            ahb_m_hready_i,
  input  logic [NUM_SUB-1:0]            ahb_m_hresp_i,
  input  logic [NUM_SUB-1:0][31:0]      ahb_m_hrdata_i,
  output logic [31:0]                   err_addr_o,
  output logic [ERR_CNT_W-1:0]          err_cnt_o,
  output logic                          err_irq_o
);
  localparam int HI   = SEL_LSB + SEL_W;
  localparam int HI_W = 32 - HI;
  localparam logic [HI_W-1:0] BASE_HI = REGION_BASE[HI_W-1:0];

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_t;

  ds_t                      ds_q, ds_d;
  logic [SEL_W-1:0]         idx;
  logic                     region_ok, mapped, accept, unmapped_acc;
  logic [NUM_SUB-1:0]       hit, dsel_sub, rdy_g, rsp_g;
  logic [NUM_SUB-1:0][31:0] rd_g;
  logic                     dsel_def;
  logic                     ds_hready, ds_hresp;
  logic                     mux_hready, mux_hresp;
  logic [31:0]              mux_hrdata;

  assign idx          = ahb_s0_haddr_i[HI-1:SEL_LSB];
  assign region_ok    = (ahb_s0_haddr_i[31:HI] == BASE_HI);
  assign mapped       = |hit;
  assign accept       = ahb_s0_hready_o & ahb_s0_htrans_i[1];
  assign unmapped_acc = accept & ~mapped;

  genvar k;
  generate
    for (k = 0; k < NUM_SUB; k++) begin : g_sub
      assign hit[k]               = region_ok && (idx == SEL_W'(k));
      assign ahb_m_haddr_o[k]     = ahb_s0_haddr_i;
      assign ahb_m_hwrite_o[k]    = ahb_s0_hwrite_i;
      assign ahb_m_hsize_o[k]     = ahb_s0_hsize_i;
      assign ahb_m_hburst_o[k]    = ahb_s0_hburst_i;
      assign ahb_m_hprot_o[k]     = ahb_s0_hprot_i;
      assign ahb_m_hmastlock_o[k] = ahb_s0_hmastlock_i;
      assign ahb_m_hwdata_o[k]    = ahb_s0_hwdata_i;
      ahb_ic_slice u_slice (
        .resetn     (resetn),
        .hit        (hit[k]),
        .sel        (dsel_sub[k]),
        .up_hready  (ahb_s0_hready_o),
        .up_htrans  (ahb_s0_htrans_i),
        .sub_hready (ahb_m_hready_i[k]),
        .sub_hresp  (ahb_m_hresp_i[k]),
        .sub_hrdata (ahb_m_hrdata_i[k]),
        .sub_htrans (ahb_m_htrans_o[k]),
        .rdy_g      (rdy_g[k]),
        .rsp_g      (rsp_g[k]),
        .rd_g       (rd_g[k])
      );
    end
  endgenerate

  // Data-phase owner: one-hot subordinate select, or the error subordinate, or none.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dsel_sub <= '0;
      dsel_def <= 1'b0;
    end else if (ahb_s0_hready_o) begin
      dsel_sub <= accept ? hit : '0;
      dsel_def <= unmapped_acc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ds_q <= DS_IDLE;
    else         ds_q <= ds_d;
  end

  always_comb begin
    ds_d      = ds_q;
    ds_hready = 1'b1;
    ds_hresp  = 1'b0;
    case (ds_q)
      DS_IDLE: if (unmapped_acc) ds_d = DS_ERR1;
      DS_ERR1: begin
        ds_hready = 1'b0;
        ds_hresp  = 1'b1;
        ds_d      = DS_ERR2;
      end
      DS_ERR2: begin
        ds_hresp = 1'b1;
        ds_d     = unmapped_acc ? DS_ERR1 : DS_IDLE;
      end
      default: ds_d = DS_IDLE;
    endcase
  end

  always_comb begin
    mux_hready = 1'b0;
    mux_hresp  = 1'b0;
    mux_hrdata = 32'h0;
    for (int i = 0; i < NUM_SUB; i++) begin
      mux_hready = mux_hready | rdy_g[i];
      mux_hresp  = mux_hresp  | rsp_g[i];
      mux_hrdata = mux_hrdata | rd_g[i];
    end
  end

  always_comb begin
    ahb_s0_hready_o = 1'b1;
    ahb_s0_hresp_o  = 1'b0;
    ahb_s0_hrdata_o = 32'h0;
    if (dsel_def) begin
      ahb_s0_hready_o = ds_hready;
      ahb_s0_hresp_o  = ds_hresp;
    end else if (|dsel_sub) begin
      ahb_s0_hready_o = mux_hready;
      ahb_s0_hresp_o  = mux_hresp;
      ahb_s0_hrdata_o = mux_hrdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_addr_o <= 32'h0;
      err_cnt_o  <= '0;
      err_irq_o  <= 1'b0;
    end else begin
      err_irq_o <= unmapped_acc;
      if (unmapped_acc) begin
        err_addr_o <= ahb_s0_haddr_i;
        if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ahb_interconnect_n.sv
// Directed bench for ahb_interconnect_n (NUM_SUB=3): decode, stall, error subordinate, reset, saturation.

module tb_ahb_interconnect_n;
  localparam int NS = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic [31:0]       haddr, hwdata;
  logic              hwrite, hmastlock;
  logic [2:0]        hsize, hburst;
  logic [3:0]        hprot;
  logic [1:0]        htrans;
  logic              hready_o, hresp_o;
  logic [31:0]       hrdata_o;
  logic [NS-1:0][31:0] m_haddr, m_hwdata, m_hrdata;
  logic [NS-1:0]     m_hwrite, m_hmastlock, m_hready, m_hresp;
  logic [NS-1:0][2:0] m_hsize, m_hburst;
  logic [NS-1:0][3:0] m_hprot;
  logic [NS-1:0][1:0] m_htrans;
  logic [31:0]       err_addr;
  logic [7:0]        err_cnt;
  logic              err_irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ahb_interconnect_n dut (
    .clk(clk), .resetn(resetn),
    .ahb_s0_haddr_i(haddr), .ahb_s0_hwrite_i(hwrite), .ahb_s0_hsize_i(hsize),
    .ahb_s0_hburst_i(hburst), .ahb_s0_hprot_i(hprot), .ahb_s0_htrans_i(htrans),
    .ahb_s0_hmastlock_i(hmastlock), .ahb_s0_hwdata_i(hwdata),
    .ahb_s0_hready_o(hready_o), .ahb_s0_hresp_o(hresp_o), .ahb_s0_hrdata_o(hrdata_o),
    .ahb_m_haddr_o(m_haddr), .ahb_m_hwrite_o(m_hwrite), .ahb_m_hsize_o(m_hsize),
    .ahb_m_hburst_o(m_hburst), .ahb_m_hprot_o(m_hprot), .ahb_m_hmastlock_o(m_hmastlock),
    .ahb_m_hwdata_o(m_hwdata), .ahb_m_htrans_o(m_htrans),
    .ahb_m_hready_i(m_hready), .ahb_m_hresp_i(m_hresp), .ahb_m_hrdata_i(m_hrdata),
    .err_addr_o(err_addr), .err_cnt_o(err_cnt), .err_irq_o(err_irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle: drive at the falling edge, let comb logic settle.
  task automatic cyc(input logic [31:0] a, input logic [1:0] t, input logic w);
    @(negedge clk);
    haddr  = a;
    htrans = t;
    hwrite = w;
    #1;
  endtask

  initial begin
    resetn = 1'b0; haddr = 0; hwdata = 32'h5A5A_0000; hwrite = 0; hmastlock = 0;
    hsize = 3'd2; hburst = 3'd0; hprot = 4'h3; htrans = 2'b00;
    m_hready = '1; m_hresp = '0; m_hrdata = '0;
    #12;
    chk("rst_hready", {31'd0, hready_o}, 32'd1);
    chk("rst_hresp",  {31'd0, hresp_o},  32'd0);
    chk("rst_cnt",    {24'd0, err_cnt},  32'd0);
    chk("rst_htrans", {26'd0, m_htrans}, 32'd0);
    @(negedge clk); resetn = 1'b1;

    // 1: read to sub1
    m_hrdata[1] = 32'hCAFE_0001;
    cyc(32'h0000_1004, 2'b10, 1'b0);
    chk("t1_htrans", {26'd0, m_htrans}, {26'd0, 6'b00_10_00});
    chk("t1_bcast",  m_haddr[2], 32'h0000_1004);
    cyc(32'h0, 2'b00, 1'b0);
    chk("t1_rdata",  hrdata_o, 32'hCAFE_0001);
    chk("t1_hresp",  {31'd0, hresp_o}, 32'd0);
    chk("t1_hready", {31'd0, hready_o}, 32'd1);

    // 2: unmapped write (idx=3)
    cyc(32'h0000_3000, 2'b10, 1'b1);
    chk("t2_htrans", {26'd0, m_htrans}, 32'd0);
    cyc(32'h0, 2'b00, 1'b0);
    chk("t2_e1_rdy", {31'd0, hready_o}, 32'd0);
    chk("t2_e1_rsp", {31'd0, hresp_o},  32'd1);
    chk("t2_irq",    {31'd0, err_irq},  32'd1);
    chk("t2_addr",   err_addr, 32'h0000_3000);
    chk("t2_cnt",    {24'd0, err_cnt}, 32'd1);
    cyc(32'h0, 2'b00, 1'b0);
    chk("t2_e2_rdy", {31'd0, hready_o}, 32'd1);
    chk("t2_e2_rsp", {31'd0, hresp_o},  32'd1);
    chk("t2_irq_off",{31'd0, err_irq},  32'd0);
    cyc(32'h0, 2'b00, 1'b0);
    chk("t2_done",   {31'd0, hresp_o},  32'd0);

    // 3: sub0 stall, sub2 address held
    m_hrdata[0] = 32'h1111_1111; m_hrdata[2] = 32'h2222_2222;
    cyc(32'h0000_0000, 2'b10, 1'b0);
    chk("t3_h0", {26'd0, m_htrans}, {26'd0, 6'b00_00_10});
    m_hready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(32'h0000_2000, 2'b10, 1'b0);
      chk("t3_stall_rdy", {31'd0, hready_o}, 32'd0);
      chk("t3_stall_htr", {26'd0, m_htrans}, 32'd0);
    end
    cyc(32'h0000_2000, 2'b10, 1'b0);
    m_hready[0] = 1'b1; #1;
    chk("t3_rel_htr", {26'd0, m_htrans}, {26'd0, 6'b10_00_00});
    chk("t3_rel_dat", hrdata_o, 32'h1111_1111);
    cyc(32'h0, 2'b00, 1'b0);
    chk("t3_s2_dat", hrdata_o, 32'h2222_2222);
    chk("t3_s2_rdy", {31'd0, hready_o}, 32'd1);

    // 4: out-of-region then back-to-back unmapped
    cyc(32'h8000_0000, 2'b10, 1'b0);
    chk("t4_htrans", {26'd0, m_htrans}, 32'd0);
    cyc(32'h8000_0004, 2'b10, 1'b0);
    chk("t4_e1_rdy", {31'd0, hready_o}, 32'd0);
    chk("t4_e1_rsp", {31'd0, hresp_o},  32'd1);
    chk("t4_addr0",  err_addr, 32'h8000_0000);
    cyc(32'h8000_0004, 2'b10, 1'b0);
    chk("t4_e2_rdy", {31'd0, hready_o}, 32'd1);
    chk("t4_e2_rsp", {31'd0, hresp_o},  32'd1);
    cyc(32'h0, 2'b00, 1'b0);
    chk("t4_e1b_rdy",{31'd0, hready_o}, 32'd0);
    chk("t4_irq2",   {31'd0, err_irq},  32'd1);
    cyc(32'h0, 2'b00, 1'b0);
    chk("t4_e2b_rsp",{31'd0, hresp_o},  32'd1);
    chk("t4_e2b_rdy",{31'd0, hready_o}, 32'd1);
    cyc(32'h0, 2'b00, 1'b0);
    chk("t4_idle",   {31'd0, hresp_o},  32'd0);
    chk("t4_cnt",    {24'd0, err_cnt},  32'd3);
    chk("t4_addr1",  err_addr, 32'h8000_0004);

    // 5: reset during ERR1
    cyc(32'h0000_5000, 2'b10, 1'b0);
    cyc(32'h0000_0000, 2'b10, 1'b0);
    chk("t5_in_e1", {31'd0, hready_o}, 32'd0);
    resetn = 1'b0; #1;
    chk("t5_rdy",    {31'd0, hready_o}, 32'd1);
    chk("t5_rsp",    {31'd0, hresp_o},  32'd0);
    chk("t5_cnt",    {24'd0, err_cnt},  32'd0);
    chk("t5_addr",   err_addr, 32'd0);
    chk("t5_htrans", {26'd0, m_htrans}, 32'd0);
    @(negedge clk); resetn = 1'b1;
    m_hrdata[0] = 32'h0000_ABCD;
    cyc(32'h0000_0010, 2'b10, 1'b0);
    chk("t5_s0_htr", {26'd0, m_htrans}, {26'd0, 6'b00_00_10});
    cyc(32'h0, 2'b00, 1'b0);
    chk("t5_s0_dat", hrdata_o, 32'h0000_ABCD);
    chk("t5_s0_rsp", {31'd0, hresp_o}, 32'd0);

    // 6: 300 unmapped accesses, one accept every two cycles
    cyc(32'h0, 2'b00, 1'b0);
    for (int i = 0; i < 600; i++) begin
      cyc(32'h0000_7000, 2'b10, 1'b0);
      if (i == 508) chk("t6_cnt254", {24'd0, err_cnt}, 32'd254);
      if (i == 510) chk("t6_cnt255", {24'd0, err_cnt}, 32'd255);
    end
    cyc(32'h0, 2'b00, 1'b0);
    cyc(32'h0, 2'b00, 1'b0);
    cyc(32'h0, 2'b00, 1'b0);
    chk("t6_sat", {24'd0, err_cnt}, 32'd255);
    chk("t6_idle", {31'd0, hresp_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
